// File: rtl/alarm_ctrl_if.sv
// Key, time and alarm-display signal bundle between the keypad/clock side and alarm_ctrl.
// Pure wiring, no latency of its own.
// No backpressure: every signal is a level sampled each clock.
interface alarm_ctrl_if;
  logic [3:0] KEY_IN;
  logic [3:0] HOURS2;
  logic [3:0] HOURS1;
  logic [3:0] MINUTES2;
  logic [3:0] MINUTES1;
  logic [3:0] SECONDS2;
  logic [3:0] SECONDS1;
  logic [3:0] ALM_H2;
  logic [3:0] ALM_H1;
  logic [3:0] ALM_M2;
  logic [3:0] ALM_M1;
  logic       DISP_ALM;
  logic       ALARM_EN;
  logic       BEEP;

  // Keypad/clock side: drives keys and time, observes alarm outputs.
  modport master (
    output KEY_IN, HOURS2, HOURS1, MINUTES2, MINUTES1, SECONDS2, SECONDS1,
    input  ALM_H2, ALM_H1, ALM_M2, ALM_M1, DISP_ALM, ALARM_EN, BEEP
  );

  // Alarm controller side.
  modport slave (
    input  KEY_IN, HOURS2, HOURS1, MINUTES2, MINUTES1, SECONDS2, SECONDS1,
    output ALM_H2, ALM_H1, ALM_M2, ALM_M1, DISP_ALM, ALARM_EN, BEEP
  );
endinterface

// File: rtl/alarm_ctrl.sv
// Alarm stage: holds alarm HH:MM, runs set/ring/snooze FSM, gates the beeper tone.
// Latency: key press acts 2 edges after the key falls; time match acts 2 edges after the time changes.
// No backpressure: keys and time are sampled every cycle, all outputs are registered.
module alarm_ctrl #(
  parameter int CLK_FREQ     = 50000000,
  parameter int TONE_HZ      = 2000,
  parameter int RING_SECONDS = 60,
  parameter int SNOOZE_MIN   = 5
) (
  input  logic         CLK_50M,
  input  logic         RST,
  alarm_ctrl_if.slave  io_alm
);

  localparam int TONE_HALF = CLK_FREQ / (2 * TONE_HZ);
  localparam int GATE_HALF = CLK_FREQ / 2;
  localparam int SNZ_TICKS = SNOOZE_MIN * 60;
  localparam int TONE_W    = $clog2(TONE_HALF + 1);
  localparam int GATE_W    = $clog2(GATE_HALF + 1);
  localparam int RING_W    = $clog2(RING_SECONDS + 1);
  localparam int SNZ_W     = $clog2(SNZ_TICKS + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SET_HOUR = 3'd1,
    S_SET_MIN  = 3'd2,
    S_RINGING  = 3'd3,
    S_SNOOZE   = 3'd4
  } state_t;

  state_t              r_state;
  logic [3:0]          r_key;
  logic [3:0]          r_key_prev;
  logic [3:0]          r_h2, r_h1, r_m2, r_m1, r_s2, r_s1;
  logic [3:0]          r_s1_prev;
  logic                r_match_prev;
  logic [3:0]          r_alm_h2, r_alm_h1, r_alm_m2, r_alm_m1;
  logic                r_en;
  logic                r_disp;
  logic                r_beep;
  logic                r_tone;
  logic                r_gate;
  logic [TONE_W-1:0]   r_tone_cnt;
  logic [GATE_W-1:0]   r_gate_cnt;
  logic [RING_W-1:0]   r_ring_cnt;
  logic [SNZ_W-1:0]    r_snz_cnt;

  logic [3:0]          w_press;
  logic                w_k_snz, w_k_en, w_k_mode, w_k_inc;
  logic                w_tick;
  logic                w_match;
  logic                w_trig;
  logic [3:0]          w_hr_h2, w_hr_h1, w_mn_m2, w_mn_m1;
  logic                w_tone_wrap, w_gate_wrap;
  logic                w_tone_nxt, w_gate_nxt;

  // Register keys and time once; previous copies give edges and second ticks.
  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      r_key        <= 4'hF;
      r_key_prev   <= 4'hF;
      r_h2         <= 4'd0;
      r_h1         <= 4'd0;
      r_m2         <= 4'd0;
      r_m1         <= 4'd0;
      r_s2         <= 4'd0;
      r_s1         <= 4'd0;
      r_s1_prev    <= 4'd0;
      r_match_prev <= 1'b0;
    end else begin
      r_key        <= io_alm.KEY_IN;
      r_key_prev   <= r_key;
      r_h2         <= io_alm.HOURS2;
      r_h1         <= io_alm.HOURS1;
      r_m2         <= io_alm.MINUTES2;
      r_m1         <= io_alm.MINUTES1;
      r_s2         <= io_alm.SECONDS2;
      r_s1         <= io_alm.SECONDS1;
      r_s1_prev    <= r_s1;
      r_match_prev <= w_match;
    end
  end

  // Press pulses with fixed priority snooze > enable > mode > increment, plus tick/trigger.
  always_comb begin
    w_press  = r_key_prev & ~r_key;
    w_k_snz  = w_press[3];
    w_k_en   = w_press[2] & ~w_press[3];
    w_k_mode = w_press[0] & ~w_press[3] & ~w_press[2];
    w_k_inc  = w_press[1] & ~w_press[3] & ~w_press[2] & ~w_press[0];
    w_tick   = (r_s1 != r_s1_prev);
    w_match  = (r_h2 == r_alm_h2) && (r_h1 == r_alm_h1) &&
               (r_m2 == r_alm_m2) && (r_m1 == r_alm_m1) &&
               (r_s2 == 4'd0) && (r_s1 == 4'd0);
    w_trig   = w_match & ~r_match_prev;
  end

  // Next BCD alarm hour (00..23) and minute (00..59) for the increment key.
  always_comb begin
    w_hr_h2 = r_alm_h2;
    w_hr_h1 = r_alm_h1 + 4'd1;
    if (r_alm_h2 == 4'd2 && r_alm_h1 == 4'd3) begin
      w_hr_h2 = 4'd0;
      w_hr_h1 = 4'd0;
    end else if (r_alm_h1 == 4'd9) begin
      w_hr_h2 = r_alm_h2 + 4'd1;
      w_hr_h1 = 4'd0;
    end
    w_mn_m2 = r_alm_m2;
    w_mn_m1 = r_alm_m1 + 4'd1;
    if (r_alm_m1 == 4'd9) begin
      w_mn_m1 = 4'd0;
      w_mn_m2 = (r_alm_m2 == 4'd5) ? 4'd0 : r_alm_m2 + 4'd1;
    end
  end

  // Tone and gate levels one cycle ahead, so BEEP is registered without extra lag.
  always_comb begin
    w_tone_wrap = (r_tone_cnt == TONE_W'(TONE_HALF - 1));
    w_gate_wrap = (r_gate_cnt == GATE_W'(GATE_HALF - 1));
    w_tone_nxt  = r_tone ^ w_tone_wrap;
    w_gate_nxt  = r_gate ^ w_gate_wrap;
  end

  // Alarm state machine with registered digits, LED, display select and beeper.
  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_alm_h2   <= 4'd0;
      r_alm_h1   <= 4'd7;
      r_alm_m2   <= 4'd0;
      r_alm_m1   <= 4'd0;
      r_en       <= 1'b0;
      r_disp     <= 1'b0;
      r_beep     <= 1'b0;
      r_tone     <= 1'b0;
      r_gate     <= 1'b0;
      r_tone_cnt <= '0;
      r_gate_cnt <= '0;
      r_ring_cnt <= '0;
      r_snz_cnt  <= '0;
    end else begin
      r_beep <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_k_mode) begin
            r_state <= S_SET_HOUR;
            r_disp  <= 1'b1;
          end else if (w_k_en) begin
            r_en <= ~r_en;
          end else if (w_trig && r_en) begin
            // Fresh ring: first gate half on, tone starts low.
            r_state    <= S_RINGING;
            r_ring_cnt <= '0;
            r_tone_cnt <= '0;
            r_gate_cnt <= '0;
            r_tone     <= 1'b0;
            r_gate     <= 1'b1;
          end
        end
        S_SET_HOUR: begin
          if (w_k_inc) begin
            r_alm_h2 <= w_hr_h2;
            r_alm_h1 <= w_hr_h1;
          end else if (w_k_mode) begin
            r_state <= S_SET_MIN;
          end
        end
        S_SET_MIN: begin
          if (w_k_inc) begin
            r_alm_m2 <= w_mn_m2;
            r_alm_m1 <= w_mn_m1;
          end else if (w_k_mode) begin
            r_state <= S_IDLE;
            r_disp  <= 1'b0;
          end
        end
        S_RINGING: begin
          if (w_k_snz) begin
            r_state   <= S_SNOOZE;
            r_snz_cnt <= '0;
          end else if (w_k_en) begin
            r_state <= S_IDLE;
          end else if (w_tick && r_ring_cnt == RING_W'(RING_SECONDS - 1)) begin
            r_state <= S_IDLE;
          end else begin
            if (w_tick) begin
              r_ring_cnt <= r_ring_cnt + RING_W'(1);
            end
            r_tone_cnt <= w_tone_wrap ? '0 : r_tone_cnt + TONE_W'(1);
            r_gate_cnt <= w_gate_wrap ? '0 : r_gate_cnt + GATE_W'(1);
            r_tone     <= w_tone_nxt;
            r_gate     <= w_gate_nxt;
            r_beep     <= w_tone_nxt & w_gate_nxt;
          end
        end
        S_SNOOZE: begin
          if (w_k_en) begin
            r_state <= S_IDLE;
          end else if (w_tick) begin
            if (r_snz_cnt == SNZ_W'(SNZ_TICKS - 1)) begin
              r_state    <= S_RINGING;
              r_ring_cnt <= '0;
              r_tone_cnt <= '0;
              r_gate_cnt <= '0;
              r_tone     <= 1'b0;
              r_gate     <= 1'b1;
            end else begin
              r_snz_cnt <= r_snz_cnt + SNZ_W'(1);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_disp  <= 1'b0;
        end
      endcase
    end
  end

  assign io_alm.ALM_H2   = r_alm_h2;
  assign io_alm.ALM_H1   = r_alm_h1;
  assign io_alm.ALM_M2   = r_alm_m2;
  assign io_alm.ALM_M1   = r_alm_m1;
  assign io_alm.DISP_ALM = r_disp;
  assign io_alm.ALARM_EN = r_en;
  assign io_alm.BEEP     = r_beep;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl against an event-level behavioural model.
// Keys and time are driven on the falling clock edge; outputs sampled away from the rising edge.
// Stimulus is a directed scenario list followed by randomized key/time traffic.
module tb_alarm_ctrl;
  localparam int CLK_FREQ     = 1000;
  localparam int TONE_HZ      = 100;
  localparam int RING_SECONDS = 4;
  localparam int SNOOZE_MIN   = 1;
  localparam int TONE_HALF    = CLK_FREQ / (2 * TONE_HZ);
  localparam int GATE_HALF    = CLK_FREQ / 2;
  localparam int SNZ_TICKS    = SNOOZE_MIN * 60;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alarm_ctrl_if bus();

  alarm_ctrl #(
    .CLK_FREQ(CLK_FREQ), .TONE_HZ(TONE_HZ),
    .RING_SECONDS(RING_SECONDS), .SNOOZE_MIN(SNOOZE_MIN)
  ) dut (
    .CLK_50M(clk),
    .RST(rst),
    .io_alm(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef enum int {M_IDLE, M_SETH, M_SETM, M_RING, M_SNZ} mstate_e;
  mstate_e mst;
  int m_h, m_m, m_ticks;
  bit m_en, m_match_prev;
  int t_h, t_m, t_s;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_beep(input int k);
    return ((k / TONE_HALF) % 2 == 1) && ((k / GATE_HALF) % 2 == 0);
  endfunction

  function automatic logic [15:0] alm_bcd(input int h, input int m);
    return 16'(((h / 10) << 12) | ((h % 10) << 8) | ((m / 10) << 4) | (m % 10));
  endfunction

  task automatic model_reset();
    mst = M_IDLE; m_h = 7; m_m = 0; m_en = 1'b0; m_ticks = 0; m_match_prev = 1'b0;
  endtask

  // Apply one key event: only the highest-priority pressed key matters.
  task automatic model_key(input logic [3:0] mask);
    int k;
    k = -1;
    if (mask[3]) k = 3;
    else if (mask[2]) k = 2;
    else if (mask[0]) k = 0;
    else if (mask[1]) k = 1;
    case (mst)
      M_IDLE: if (k == 0) mst = M_SETH; else if (k == 2) m_en = !m_en;
      M_SETH: if (k == 1) m_h = (m_h + 1) % 24; else if (k == 0) mst = M_SETM;
      M_SETM: if (k == 1) m_m = (m_m + 1) % 60; else if (k == 0) mst = M_IDLE;
      M_RING: if (k == 3) begin mst = M_SNZ; m_ticks = 0; end else if (k == 2) mst = M_IDLE;
      M_SNZ:  if (k == 2) mst = M_IDLE;
      default: ;
    endcase
    m_match_prev = (t_h == m_h && t_m == m_m && t_s == 0);
  endtask

  task automatic press(input logic [3:0] mask);
    @(negedge clk) bus.KEY_IN = ~mask;
    @(negedge clk) bus.KEY_IN = 4'hF;
    @(negedge clk);
    model_key(mask);
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  // Drive a new time; returns just after the edge where the DUT acts on it.
  task automatic time_step(input int h, input int m, input int s);
    bit tick, match;
    tick  = ((s % 10) != (t_s % 10));
    match = (h == m_h && m == m_m && s == 0);
    @(negedge clk);
    bus.HOURS2 = 4'(h / 10);   bus.HOURS1 = 4'(h % 10);
    bus.MINUTES2 = 4'(m / 10); bus.MINUTES1 = 4'(m % 10);
    bus.SECONDS2 = 4'(s / 10); bus.SECONDS1 = 4'(s % 10);
    @(posedge clk);
    @(posedge clk);
    #1;
    if (mst == M_IDLE) begin
      if (match && !m_match_prev && m_en) begin mst = M_RING; m_ticks = 0; end
    end else if (tick) begin
      if (mst == M_RING) begin
        m_ticks++;
        if (m_ticks == RING_SECONDS) mst = M_IDLE;
      end else if (mst == M_SNZ) begin
        m_ticks++;
        if (m_ticks == SNZ_TICKS) begin mst = M_RING; m_ticks = 0; end
      end
    end
    m_match_prev = match;
    t_h = h; t_m = m; t_s = s;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ":alm"}, {bus.ALM_H2, bus.ALM_H1, bus.ALM_M2, bus.ALM_M1}, alm_bcd(m_h, m_m));
    check({tag, ":disp"}, bus.DISP_ALM, (mst == M_SETH || mst == M_SETM));
    check({tag, ":en"}, bus.ALARM_EN, m_en);
    if (mst != M_RING) check({tag, ":beep"}, bus.BEEP, 1'b0);
  endtask

  task automatic quiet(input int n, input string tag);
    int highs;
    highs = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.BEEP) highs++;
    end
    check(tag, highs, 0);
  endtask

  // Called right after the ring-entry edge; k counts edges since entry.
  task automatic beep_window(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      check($sformatf("%s[%0d]", tag, k), bus.BEEP, exp_beep(k));
    end
  endtask

  task automatic snooze_ticks(input string tag);
    for (int i = 1; i <= SNZ_TICKS; i++) begin
      time_step(0, 1, (i % 2 == 1) ? 1 : 2);
      if (i == SNZ_TICKS / 2) quiet(10, {tag, "_mid"});
    end
  endtask

  initial begin
    bus.KEY_IN = 4'hF;
    bus.HOURS2 = 0; bus.HOURS1 = 0; bus.MINUTES2 = 0; bus.MINUTES1 = 0;
    bus.SECONDS2 = 0; bus.SECONDS1 = 0;
    t_h = 0; t_m = 0; t_s = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check_outputs("reset");
    check("reset_alm_0700", {bus.ALM_H2, bus.ALM_H1, bus.ALM_M2, bus.ALM_M1}, 16'h0700);

    // Disarmed alarm at its own time stays silent.
    time_step(7, 0, 0);
    quiet(20, "disarmed_quiet");

    // Set alarm: hours 07+17 wraps to 00, minutes 00+61 ends at 01.
    press(4'b0001);
    check_outputs("set_hour");
    repeat (17) press(4'b0010);
    check_outputs("hour_wrap");
    press(4'b0001);
    check_outputs("set_min");
    repeat (61) press(4'b0010);
    check_outputs("min_wrap");
    press(4'b0001);
    check_outputs("set_done");
    check("alm_0001", {bus.ALM_H2, bus.ALM_H1, bus.ALM_M2, bus.ALM_M1}, 16'h0001);

    // Arm and trigger; full tone/gate pattern with time held at :00.
    press(4'b0100);
    check_outputs("armed");
    time_step(0, 0, 59);
    time_step(0, 1, 0);
    beep_window(2 * GATE_HALF, "ring1");
    press(4'b0100);
    quiet(30, "fires_once");
    check_outputs("stopped");

    // Auto-stop after RING_SECONDS ticks.
    time_step(0, 0, 58);
    time_step(0, 1, 0);
    for (int s = 1; s <= RING_SECONDS; s++) time_step(0, 1, s);
    quiet(20, "timeout_quiet");
    check_outputs("timeout");

    // Snooze then re-ring with fresh timing, then stop.
    time_step(0, 0, 57);
    time_step(0, 1, 0);
    beep_window(12, "ring2");
    press(4'b1000);
    check_outputs("snooze");
    snooze_ticks("snz1");
    beep_window(12, "reRing");
    press(4'b0100);
    quiet(20, "stop_quiet");
    check_outputs("stop");

    // Disarm: no trigger afterwards.
    press(4'b0100);
    check_outputs("disarm");
    time_step(0, 0, 55);
    time_step(0, 1, 0);
    quiet(20, "disarm_quiet");
    check_outputs("disarm_after");

    // Re-arm; a match arriving during set is suppressed.
    press(4'b0100);
    press(4'b0001);
    time_step(0, 0, 59);
    time_step(0, 1, 0);
    check_outputs("set_suppress");
    press(4'b0001);
    press(4'b0001);
    quiet(20, "suppress_quiet");
    check_outputs("suppress_after");

    // Snooze and stop pressed together: snooze wins; then reset mid-ring.
    time_step(0, 0, 56);
    time_step(0, 1, 0);
    press(4'b1100);
    check_outputs("prio");
    snooze_ticks("snz2");
    beep_window(TONE_HALF + 2, "ring3");
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    check("rst_beep", bus.BEEP, 1'b0);
    check("rst_alm", {bus.ALM_H2, bus.ALM_H1, bus.ALM_M2, bus.ALM_M1}, 16'h0700);
    check("rst_en", bus.ALARM_EN, 1'b0);
    @(negedge clk) rst = 1'b0;

    // Randomized keys and non-matching times.
    time_step(12, 34, 56);
    for (int i = 0; i < 40; i++) begin
      int r;
      logic [3:0] mask;
      r = $urandom_range(0, 9);
      if (r < 4) mask = 4'b0010;
      else if (r < 6) mask = 4'b0001;
      else if (r < 7) mask = 4'b0100;
      else if (r < 8) mask = 4'b1000;
      else mask = 4'($urandom_range(1, 15));
      press(mask);
      check_outputs($sformatf("rnd%0d", i));
      if (r == 9) time_step($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(1, 59));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
